// File: rtl/toy_bpu_btb_ctrl.sv
// BTB entry/PLRU memory port controller: serializes lookups and updates through one
// single-ported, 1-cycle-latency SRAM and performs the PLRU read-modify-write.
module toy_bpu_btb_ctrl #(
    parameter int WAY_NUM     = 4,
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 12,
    parameter int ENTRY_WIDTH = 48
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           lkp_vld,
    output logic                           lkp_rdy,
    input  logic [INDEX_WIDTH-1:0]         lkp_index,
    input  logic [TAG_WIDTH-1:0]           lkp_tag,
    output logic                           rsp_vld,
    output logic                           rsp_hit,
    output logic [$clog2(WAY_NUM)-1:0]     rsp_way,
    output logic [ENTRY_WIDTH-1:0]         rsp_entry,
    input  logic                           upd_vld,
    output logic                           upd_rdy,
    input  logic [INDEX_WIDTH-1:0]         upd_index,
    input  logic [ENTRY_WIDTH-1:0]         upd_entry,
    output logic                           mem_req_vld,
    output logic [WAY_NUM-1:0]             mem_req_wren,
    output logic [INDEX_WIDTH-1:0]         mem_req_addr,
    output logic [WAY_NUM*ENTRY_WIDTH-1:0] mem_req_wdata_way,
    output logic [WAY_NUM-2:0]             mem_req_wdata_node,
    input  logic [WAY_NUM*ENTRY_WIDTH-1:0] mem_ack_rdata_way,
    input  logic [WAY_NUM-2:0]             mem_ack_rdata_node
);

    localparam int WAY_W  = $clog2(WAY_NUM);
    localparam int NODE_W = WAY_NUM - 1;
    localparam int BUS_W  = WAY_NUM * ENTRY_WIDTH;

    typedef enum logic [1:0] {IDLE, LKP_CMP, UPD_SEL} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     upd_acc;
    logic                     lkp_acc;
    logic [INDEX_WIDTH-1:0]   req_index_p0;
    logic [TAG_WIDTH-1:0]     req_tag_p0;
    logic [ENTRY_WIDTH-1:0]   req_entry_p0;
    logic [ENTRY_WIDTH-1:0]   rd_entry [WAY_NUM];
    logic [TAG_WIDTH-1:0]     cmp_tag;
    logic                     match_hit;
    logic [WAY_W-1:0]         match_way;
    logic [ENTRY_WIDTH-1:0]   match_entry;
    logic                     free_hit;
    logic [WAY_W-1:0]         free_way;
    logic [WAY_W-1:0]         sel_way;
    logic [ENTRY_WIDTH-1:0]   wr_entry;
    logic                     wr_en;

    // Heap-ordered tree walk; a 0 bit steers toward the lower-way child.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODE_W-1:0] node);
        logic [NODE_W-1:0] sh;
        int k;
        k = 0;
        for (int l = 0; l < WAY_W; l++) begin
            sh = node >> k;
            k  = 2 * k + 1 + int'(sh[0]);
        end
        return WAY_W'(k - NODE_W);
    endfunction

    function automatic logic [NODE_W-1:0] plru_touch(input logic [NODE_W-1:0] node,
                                                     input logic [WAY_W-1:0]  way);
        logic [NODE_W-1:0] n;
        logic [WAY_W-1:0]  sw;
        logic              d;
        int k;
        n = node;
        k = 0;
        for (int l = 0; l < WAY_W; l++) begin
            sw = way >> (WAY_W - 1 - l);
            d  = sw[0];
            if (d) n = n & ~(NODE_W'(1) << k);
            else   n = n | (NODE_W'(1) << k);
            k = 2 * k + 1 + int'(d);
        end
        return n;
    endfunction

    assign upd_rdy = (state == IDLE);
    assign lkp_rdy = (state == IDLE) && !upd_vld;
    assign upd_acc = upd_vld && upd_rdy;
    assign lkp_acc = lkp_vld && lkp_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (upd_acc)      state_nxt = UPD_SEL;
                else if (lkp_acc) state_nxt = LKP_CMP;
            end
            LKP_CMP: state_nxt = IDLE;
            UPD_SEL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request captured at acceptance, held while the read returns
    always_ff @(posedge clk) begin
        if (upd_acc) begin
            req_index_p0 <= upd_index;
            req_entry_p0 <= upd_entry;
        end else if (lkp_acc) begin
            req_index_p0 <= lkp_index;
            req_tag_p0   <= lkp_tag;
        end
    end

    always_comb begin
        cmp_tag     = (state == UPD_SEL) ? req_entry_p0[ENTRY_WIDTH-2 -: TAG_WIDTH] : req_tag_p0;
        match_hit   = 1'b0;
        match_way   = '0;
        match_entry = '0;
        free_hit    = 1'b0;
        free_way    = '0;
        // Descending scan so the lowest matching index is the last one written.
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            rd_entry[i] = mem_ack_rdata_way[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            if (rd_entry[i][ENTRY_WIDTH-1] && rd_entry[i][ENTRY_WIDTH-2 -: TAG_WIDTH] == cmp_tag) begin
                match_hit   = 1'b1;
                match_way   = WAY_W'(i);
                match_entry = rd_entry[i];
            end
            if (!rd_entry[i][ENTRY_WIDTH-1]) begin
                free_hit = 1'b1;
                free_way = WAY_W'(i);
            end
        end
        if (state == UPD_SEL) begin
            sel_way  = match_hit ? match_way : (free_hit ? free_way : plru_victim(mem_ack_rdata_node));
            wr_entry = req_entry_p0;
            wr_en    = 1'b1;
        end else begin
            sel_way  = match_way;
            wr_entry = match_entry;
            wr_en    = (state == LKP_CMP) && match_hit;
        end
    end

    always_comb begin
        mem_req_vld        = 1'b0;
        mem_req_wren       = '0;
        mem_req_addr       = '0;
        mem_req_wdata_way  = '0;
        mem_req_wdata_node = '0;
        if (!rst) begin
            if (state == IDLE) begin
                if (upd_acc) begin
                    mem_req_vld  = 1'b1;
                    mem_req_addr = upd_index;
                end else if (lkp_acc) begin
                    mem_req_vld  = 1'b1;
                    mem_req_addr = lkp_index;
                end
            end else if (wr_en) begin
                mem_req_vld        = 1'b1;
                mem_req_addr       = req_index_p0;
                mem_req_wdata_node = plru_touch(mem_ack_rdata_node, sel_way);
                for (int i = 0; i < WAY_NUM; i++) begin
                    if (sel_way == WAY_W'(i)) begin
                        mem_req_wren[i]                               = 1'b1;
                        mem_req_wdata_way[i*ENTRY_WIDTH +: ENTRY_WIDTH] = wr_entry;
                    end
                end
            end
        end
    end

    // Stage p1: lookup result registered out of the compare cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld   <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
            rsp_entry <= '0;
        end else begin
            rsp_vld <= (state == LKP_CMP);
            if (state == LKP_CMP) begin
                rsp_hit   <= match_hit;
                rsp_way   <= match_way;
                rsp_entry <= match_entry;
            end
        end
    end

endmodule

// File: tb/tb_toy_bpu_btb_ctrl.sv
// Scoreboard bench for toy_bpu_btb_ctrl: bench-side SRAM, set/PLRU reference model,
// decoupled monitor checking memory transactions and lookup responses with cycle timing.
module tb_toy_bpu_btb_ctrl;

    localparam int WAY_NUM     = 4;
    localparam int INDEX_WIDTH = 7;
    localparam int TAG_WIDTH   = 12;
    localparam int ENTRY_WIDTH = 48;
    localparam int WAY_W       = $clog2(WAY_NUM);
    localparam int NODE_W      = WAY_NUM - 1;
    localparam int BUS_W       = WAY_NUM * ENTRY_WIDTH;
    localparam int PL_W        = ENTRY_WIDTH - 1 - TAG_WIDTH;
    localparam int SETS        = 1 << INDEX_WIDTH;

    logic                   clk;
    logic                   rst;
    logic                   lkp_vld;
    logic                   lkp_rdy;
    logic [INDEX_WIDTH-1:0] lkp_index;
    logic [TAG_WIDTH-1:0]   lkp_tag;
    logic                   rsp_vld;
    logic                   rsp_hit;
    logic [WAY_W-1:0]       rsp_way;
    logic [ENTRY_WIDTH-1:0] rsp_entry;
    logic                   upd_vld;
    logic                   upd_rdy;
    logic [INDEX_WIDTH-1:0] upd_index;
    logic [ENTRY_WIDTH-1:0] upd_entry;
    logic                   mem_req_vld;
    logic [WAY_NUM-1:0]     mem_req_wren;
    logic [INDEX_WIDTH-1:0] mem_req_addr;
    logic [BUS_W-1:0]       mem_req_wdata_way;
    logic [NODE_W-1:0]      mem_req_wdata_node;
    logic [BUS_W-1:0]       mem_ack_rdata_way;
    logic [NODE_W-1:0]      mem_ack_rdata_node;

    toy_bpu_btb_ctrl #(
        .WAY_NUM(WAY_NUM), .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH(TAG_WIDTH), .ENTRY_WIDTH(ENTRY_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .lkp_vld(lkp_vld), .lkp_rdy(lkp_rdy), .lkp_index(lkp_index), .lkp_tag(lkp_tag),
        .rsp_vld(rsp_vld), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_entry(rsp_entry),
        .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_index(upd_index), .upd_entry(upd_entry),
        .mem_req_vld(mem_req_vld), .mem_req_wren(mem_req_wren), .mem_req_addr(mem_req_addr),
        .mem_req_wdata_way(mem_req_wdata_way), .mem_req_wdata_node(mem_req_wdata_node),
        .mem_ack_rdata_way(mem_ack_rdata_way), .mem_ack_rdata_node(mem_ack_rdata_node)
    );

    typedef struct {
        int                     cyc;
        bit                     wr;
        logic [INDEX_WIDTH-1:0] addr;
        logic [WAY_NUM-1:0]     wren;
        logic [BUS_W-1:0]       wdata;
        logic [NODE_W-1:0]      node;
    } mem_txn_t;

    typedef struct {
        int                     cyc;
        bit                     hit;
        logic [WAY_W-1:0]       way;
        logic [ENTRY_WIDTH-1:0] entry;
    } rsp_txn_t;

    mem_txn_t mq[$];
    rsp_txn_t rq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // bench-side SRAM
    logic [ENTRY_WIDTH-1:0] mem_way [SETS][WAY_NUM];
    logic [NODE_W-1:0]      mem_node [SETS];
    // reference model of the architectural set contents
    logic [ENTRY_WIDTH-1:0] ref_way [SETS][WAY_NUM];
    logic [NODE_W-1:0]      ref_node [SETS];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (mem_req_vld) begin
            if (|mem_req_wren) begin
                for (int w = 0; w < WAY_NUM; w++)
                    if (mem_req_wren[w]) mem_way[mem_req_addr][w] <= mem_req_wdata_way[w*ENTRY_WIDTH +: ENTRY_WIDTH];
                mem_node[mem_req_addr] <= mem_req_wdata_node;
            end else begin
                for (int w = 0; w < WAY_NUM; w++)
                    mem_ack_rdata_way[w*ENTRY_WIDTH +: ENTRY_WIDTH] <= mem_way[mem_req_addr][w];
                mem_ack_rdata_node <= mem_node[mem_req_addr];
            end
        end
    end

    // Range-based PLRU: each tree node splits [lo, lo+size) into halves.
    function automatic logic [NODE_W-1:0] ref_touch(input logic [NODE_W-1:0] n, input int w);
        int k, lo, size, half;
        k = 0; lo = 0; size = WAY_NUM;
        while (size > 1) begin
            half = size / 2;
            if (w < lo + half) begin
                n = n | (NODE_W'(1) << k);
                k = 2 * k + 1;
            end else begin
                n = n & ~(NODE_W'(1) << k);
                lo = lo + half;
                k = 2 * k + 2;
            end
            size = half;
        end
        return n;
    endfunction

    function automatic int ref_victim(input logic [NODE_W-1:0] n);
        int k, lo, size, half;
        logic [NODE_W-1:0] sh;
        k = 0; lo = 0; size = WAY_NUM;
        while (size > 1) begin
            half = size / 2;
            sh = n >> k;
            if (sh[0] == 1'b0) begin
                k = 2 * k + 1;
            end else begin
                lo = lo + half;
                k = 2 * k + 2;
            end
            size = half;
        end
        return lo;
    endfunction

    function automatic logic [ENTRY_WIDTH-1:0] mk_entry(input bit v, input logic [TAG_WIDTH-1:0] t,
                                                       input logic [PL_W-1:0] pl);
        return {v, t, pl};
    endfunction

    function automatic mem_txn_t mk_write(input int c, input logic [INDEX_WIDTH-1:0] idx, input int w,
                                          input logic [ENTRY_WIDTH-1:0] e, input logic [NODE_W-1:0] n);
        mem_txn_t m;
        m.cyc = c; m.wr = 1'b1; m.addr = idx; m.node = n;
        m.wren = '0;
        m.wren = m.wren | (WAY_NUM'(1) << w);
        m.wdata = '0;
        m.wdata[w*ENTRY_WIDTH +: ENTRY_WIDTH] = e;
        return m;
    endfunction

    task automatic push_read(input int c, input logic [INDEX_WIDTH-1:0] idx);
        mem_txn_t m;
        m.cyc = c; m.wr = 1'b0; m.addr = idx; m.wren = '0; m.wdata = '0; m.node = '0;
        mq.push_back(m);
    endtask

    task automatic model_lkp(input int c, input logic [INDEX_WIDTH-1:0] idx, input logic [TAG_WIDTH-1:0] t);
        rsp_txn_t r;
        int hw;
        push_read(c, idx);
        hw = -1;
        for (int w = 0; w < WAY_NUM; w++)
            if (hw < 0 && ref_way[idx][w][ENTRY_WIDTH-1] && ref_way[idx][w][ENTRY_WIDTH-2 -: TAG_WIDTH] == t)
                hw = w;
        r.cyc = c + 2;
        r.hit = (hw >= 0);
        r.way = (hw >= 0) ? WAY_W'(hw) : '0;
        r.entry = (hw >= 0) ? ref_way[idx][hw] : '0;
        rq.push_back(r);
        if (hw >= 0) begin
            ref_node[idx] = ref_touch(ref_node[idx], hw);
            mq.push_back(mk_write(c + 1, idx, hw, ref_way[idx][hw], ref_node[idx]));
        end
    endtask

    task automatic model_upd(input int c, input logic [INDEX_WIDTH-1:0] idx,
                             input logic [ENTRY_WIDTH-1:0] e, input bit drop);
        int tw;
        push_read(c, idx);
        if (drop) return;
        tw = -1;
        for (int w = 0; w < WAY_NUM; w++)
            if (tw < 0 && ref_way[idx][w][ENTRY_WIDTH-1] &&
                ref_way[idx][w][ENTRY_WIDTH-2 -: TAG_WIDTH] == e[ENTRY_WIDTH-2 -: TAG_WIDTH])
                tw = w;
        for (int w = 0; w < WAY_NUM; w++)
            if (tw < 0 && !ref_way[idx][w][ENTRY_WIDTH-1]) tw = w;
        if (tw < 0) tw = ref_victim(ref_node[idx]);
        ref_way[idx][tw] = e;
        ref_node[idx] = ref_touch(ref_node[idx], tw);
        mq.push_back(mk_write(c + 1, idx, tw, e, ref_node[idx]));
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a memory request or response.
    always @(negedge clk) begin
        mem_txn_t m;
        rsp_txn_t r;
        #1;
        if (mem_req_vld) begin
            n_tests++;
            if (mq.size() == 0) begin
                n_fail++;
                $display("FAIL mem_unexpected: cyc %0d addr %0h wren %b", cyc, mem_req_addr, mem_req_wren);
            end else begin
                m = mq.pop_front();
                if (m.cyc != cyc || mem_req_addr !== m.addr || mem_req_wren !== m.wren ||
                    (m.wr && (mem_req_wdata_way !== m.wdata || mem_req_wdata_node !== m.node))) begin
                    n_fail++;
                    $display("FAIL mem_txn: got cyc %0d addr %0h wren %b node %b data %0h; expected cyc %0d addr %0h wren %b node %b data %0h",
                             cyc, mem_req_addr, mem_req_wren, mem_req_wdata_node, mem_req_wdata_way,
                             m.cyc, m.addr, m.wren, m.node, m.wdata);
                end
            end
        end
        if (rsp_vld) begin
            n_tests++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: cyc %0d hit %b", cyc, rsp_hit);
            end else begin
                r = rq.pop_front();
                if (r.cyc != cyc || rsp_hit !== r.hit || rsp_way !== r.way || rsp_entry !== r.entry) begin
                    n_fail++;
                    $display("FAIL rsp: got cyc %0d hit %b way %0d entry %0h; expected cyc %0d hit %b way %0d entry %0h",
                             cyc, rsp_hit, rsp_way, rsp_entry, r.cyc, r.hit, r.way, r.entry);
                end
            end
        end
    end

    // Issues an update and/or lookup and follows both to acceptance; models them in acceptance order.
    task automatic do_op(input bit u, input bit l,
                         input logic [INDEX_WIDTH-1:0] ui, input logic [ENTRY_WIDTH-1:0] ue,
                         input logic [INDEX_WIDTH-1:0] li, input logic [TAG_WIDTH-1:0] lt,
                         input bit drop);
        int guard;
        bit acc_u, acc_l;
        @(posedge clk); #1;
        upd_vld = u; upd_index = ui; upd_entry = ue;
        lkp_vld = l; lkp_index = li; lkp_tag = lt;
        guard = 0;
        while ((upd_vld || lkp_vld) && guard < 20) begin
            @(negedge clk);
            if (upd_vld && lkp_vld) check("lkp_rdy_blocked", 256'(lkp_rdy), 256'(0));
            acc_u = upd_vld && upd_rdy;
            acc_l = lkp_vld && lkp_rdy;
            if (acc_u) model_upd(cyc, upd_index, upd_entry, drop);
            if (acc_l) model_lkp(cyc, lkp_index, lkp_tag);
            @(posedge clk); #1;
            if (acc_u) begin
                upd_vld = 1'b0;
                upd_index = INDEX_WIDTH'($urandom);
                upd_entry = {16'($urandom), 32'($urandom)};
            end
            if (acc_l) begin
                lkp_vld = 1'b0;
                lkp_index = INDEX_WIDTH'($urandom);
                lkp_tag = TAG_WIDTH'($urandom);
            end
            if (acc_u && drop) begin
                rst = 1'b1;
                @(negedge clk); #2;
                check("rst_mem_req_vld", 256'(mem_req_vld), 256'(0));
                check("rst_mem_req_wren", 256'(mem_req_wren), 256'(0));
                check("rst_upd_rdy", 256'(upd_rdy), 256'(1));
                @(posedge clk); #1;
                rst = 1'b0;
            end
            guard++;
        end
        if (guard >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: upd_vld %b lkp_vld %b", upd_vld, lkp_vld);
            upd_vld = 1'b0; lkp_vld = 1'b0;
        end
    endtask

    initial begin
        int wait_cyc;
        logic [ENTRY_WIDTH-1:0] e;
        for (int s = 0; s < SETS; s++) begin
            mem_node[s] = '0; ref_node[s] = '0;
            for (int w = 0; w < WAY_NUM; w++) begin
                mem_way[s][w] = '0; ref_way[s][w] = '0;
            end
        end
        mem_ack_rdata_way = '0; mem_ack_rdata_node = '0;
        rst = 1'b1;
        lkp_vld = 1'b0; lkp_index = '0; lkp_tag = '0;
        upd_vld = 1'b0; upd_index = '0; upd_entry = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        check("reset_rsp", {rsp_vld, rsp_hit, 2'(rsp_way), rsp_entry}, 256'(0));
        check("reset_mem_req", {mem_req_vld, mem_req_wren, mem_req_addr, mem_req_wdata_node}, 256'(0));
        check("reset_wdata", 256'(mem_req_wdata_way), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {upd_rdy, lkp_rdy}, 256'(3));

        // Miss on empty memory, then two installs and a hit on set 5
        do_op(0, 1, 0, 0, 7'd5, 12'h012, 0);
        do_op(1, 0, 7'd5, mk_entry(1, 12'h012, 35'h1234), 0, 0, 0);
        do_op(1, 0, 7'd5, mk_entry(1, 12'h013, 35'h5678), 0, 0, 0);
        do_op(0, 1, 0, 0, 7'd5, 12'h012, 0);

        // Fill set 9, replace via PLRU victim, then update an existing tag
        for (int i = 0; i < 4; i++)
            do_op(1, 0, 7'd9, mk_entry(1, 12'h200 + 12'(i), 35'(i + 1)), 0, 0, 0);
        do_op(1, 0, 7'd9, mk_entry(1, 12'h2FF, 35'h7ABC), 0, 0, 0);
        do_op(1, 0, 7'd9, mk_entry(1, 12'h202, 35'h0DEF), 0, 0, 0);

        // Simultaneous requests: update wins, lookup follows
        do_op(1, 1, 7'd9, mk_entry(1, 12'h2AA, 35'h0111), 7'd9, 12'h202, 0);

        // Reset during an update's select cycle drops the write
        do_op(1, 0, 7'd5, mk_entry(1, 12'h0AB, 35'h0999), 0, 0, 1);
        do_op(0, 1, 0, 0, 7'd5, 12'h012, 0);
        do_op(0, 1, 0, 0, 7'd5, 12'h0AB, 0);

        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            e = mk_entry($urandom_range(0, 7) != 0, 12'h100 + 12'($urandom_range(0, 5)),
                         {3'($urandom), 32'($urandom)});
            do_op(kind >= 4, (kind < 4) || (kind >= 8),
                  7'(16 + $urandom_range(0, 3)), e,
                  7'(16 + $urandom_range(0, 3)), 12'h100 + 12'($urandom_range(0, 5)), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        wait_cyc = 0;
        while ((mq.size() != 0 || rq.size() != 0) && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk); #2;
        check("mem_queue_drained", 256'(mq.size()), 256'(0));
        check("rsp_queue_drained", 256'(rq.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/toy_bpu_btb_ctrl.md
Name: toy_bpu_btb_ctrl

Overview:
Initiator-side controller for the BTB entry/PLRU SRAM port of the BPU memory block. It drives btb_mem_req_* and consumes btb_mem_ack_rdata. It services two client streams, BTB lookups and BTB updates, and performs the read-modify-write of the per-set PLRU tree. All accesses are serialized through one single-ported, 1-cycle-read-latency memory port.

Parameters:
WAY_NUM, 4, BTB ways; power of 2, at least 2
INDEX_WIDTH, 7, set index width
TAG_WIDTH, 12, tag width
ENTRY_WIDTH, 48, bits per way entry; bit [ENTRY_WIDTH-1] = valid, bits [ENTRY_WIDTH-2 -: TAG_WIDTH] = tag, remaining bits are payload

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
lkp_vld  in  1  lookup request
lkp_rdy  out  1  lookup accepted when lkp_vld && lkp_rdy
lkp_index  in  INDEX_WIDTH  lookup set
lkp_tag  in  TAG_WIDTH  lookup tag
rsp_vld  out  1  one-cycle lookup result pulse
rsp_hit  out  1  lookup hit
rsp_way  out  $clog2(WAY_NUM)  hit way
rsp_entry  out  ENTRY_WIDTH  hit entry; zero on miss
upd_vld  in  1  update request
upd_rdy  out  1  update accepted when upd_vld && upd_rdy
upd_index  in  INDEX_WIDTH  update set
upd_entry  in  ENTRY_WIDTH  entry to install; carries its own valid and tag
mem_req_vld  out  1  memory enable
mem_req_wren  out  WAY_NUM  per-way write enable; node is written when any bit is set
mem_req_addr  out  INDEX_WIDTH  memory set address
mem_req_wdata_way  out  WAY_NUM*ENTRY_WIDTH  way write data, way i at slice i
mem_req_wdata_node  out  WAY_NUM-1  PLRU write data
mem_ack_rdata_way  in  WAY_NUM*ENTRY_WIDTH  way read data, valid the cycle after a read
mem_ack_rdata_node  in  WAY_NUM-1  PLRU read data

Behaviour:
- FSM states: IDLE, LKP_CMP, UPD_SEL.
- Reset: state=IDLE. rsp_vld, rsp_hit, rsp_way, rsp_entry, mem_req_vld, mem_req_wren, mem_req_addr and both wdata buses are 0.
- Ready signals (combinational): upd_rdy = (state==IDLE); lkp_rdy = (state==IDLE) && !upd_vld. Updates win over lookups.
- IDLE + accepted request: drive mem_req_vld=1, wren=0, addr=index in the same cycle. Register the request, then go to LKP_CMP or UPD_SEL.
- LKP_CMP (rdata valid): hit = any way with valid && tag==lkp_tag; if several match, the lowest index wins.
  - rsp_vld=1 for this cycle only, together with hit, way and entry.
  - On hit: issue write with wren=onehot(way), wdata_way[way] = read entry unchanged, node = touch(read node, way). No other memory activity on miss.
  - Next state: IDLE.
- UPD_SEL (rdata valid): target way is selected in priority order:
  1. way whose valid && tag matches upd_entry's tag (lowest index if several);
  2. otherwise the lowest-index invalid way;
  3. otherwise victim(read node).
  - Issue write with wren=onehot(way), wdata_way[way]=upd_entry, node = touch(read node, way). Unselected wdata slices are 0. Next state: IDLE.
- PLRU tree in heap order: node[0] is the root; children of node[k] are node[2k+1] and node[2k+2].
  - Bit=0 means the victim lies in the lower-way subtree.
  - victim: walk from the root following the bits.
  - touch(w): along w's path, set each bit to point away from w.
- Throughput: one operation per 2 cycles. rsp_vld asserts 2 cycles after the lkp_vld && lkp_rdy edge.
- Memory read data is sampled only in LKP_CMP or UPD_SEL. mem_req_vld=0 in IDLE with no accepted request.
- Reset mid-operation: the in-flight operation is dropped, no write is issued, and memory contents are untouched.
- Index and tag inputs are sampled only at acceptance; later changes are ignored.

Test Plan:
1. Reset, memory all 0; lookup index 5, tag 0x012 -> read addr 5; rsp_vld 2 cycles later with hit=0, entry=0; wren never set.
2. Update index 5 with valid=1, tag 0x012 -> read, then write wren=4'b0001, node=3'b011. Second update with tag 0x013 -> wren=4'b0010, node=3'b001.
3. After scenario 2, lookup index 5, tag 0x012 -> rsp_hit=1, rsp_way=0, rsp_entry=installed entry; write wren=4'b0001 with unchanged data, node=3'b011.
4. Fill ways 0..3 of set 9 in order (node ends 3'b000), then update with a new tag -> victim way 0, wren=4'b0001, node=3'b011. An update with an existing tag in way 2 -> wren=4'b0100.
5. lkp_vld and upd_vld high together in IDLE -> upd accepted, lkp_rdy=0; lookup accepted 2 cycles later and answered 2 cycles after that.
6. Assert rst in the cycle after an update is accepted -> mem_req_vld=0 and wren=0 that cycle; state=IDLE; a following lookup to that set returns the old contents.
